// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: scan codes, arrow bit positions (car_ctl ARROW_* order)
// and the state encodings of the frame receiver and the scan-code decoder.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam int ARROW_UP    = 0;
  localparam int ARROW_DOWN  = 1;
  localparam int ARROW_LEFT  = 2;
  localparam int ARROW_RIGHT = 3;

  localparam logic [1:0] FRM_IDLE   = 2'd0;
  localparam logic [1:0] FRM_DATA   = 2'd1;
  localparam logic [1:0] FRM_PARITY = 2'd2;
  localparam logic [1:0] FRM_STOP   = 2'd3;

  localparam logic [1:0] DEC_BASE    = 2'd0;
  localparam logic [1:0] DEC_EXT     = 2'd1;
  localparam logic [1:0] DEC_BRK     = 2'd2;
  localparam logic [1:0] DEC_EXT_BRK = 2'd3;

  // One-hot key mask for an extended arrow code, zero for anything else.
  function automatic logic [3:0] arrow_mask(input logic [7:0] code);
    logic [3:0] m;
    m = 4'b0000;
    case (code)
      SC_UP:    m[ARROW_UP]    = 1'b1;
      SC_DOWN:  m[ARROW_DOWN]  = 1'b1;
      SC_LEFT:  m[ARROW_LEFT]  = 1'b1;
      SC_RIGHT: m[ARROW_RIGHT] = 1'b1;
      default:  m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_arrow_decoder_if.sv
// Bundle between a PS/2 line driver (master) and the arrow decoder (slave).
// rx_valid and frame_err are single-cycle strobes with no ready/backpressure:
// a consumer must take rx_byte in the cycle rx_valid is high.
interface ps2_arrow_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] key;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic [1:0] frame_state;
  logic [1:0] dec_state;

  modport master (
    output ps2_clk, ps2_data,
    input  key, rx_byte, rx_valid, frame_err, frame_state, dec_state
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output key, rx_byte, rx_valid, frame_err, frame_state, dec_state
  );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 byte receiver: line synchronisers, ps2_clk glitch filter, 11-bit frame FSM
// with odd-parity/stop checking and an inactivity timeout.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 65000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [1:0] state
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic [FW-1:0] filt_cnt;
  logic          filt_clk;
  logic          filt_clk_d;
  logic          fall;
  logic          sample;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] to_cnt;

  // Lines idle high, so synchronisers and filter come out of reset at 1.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      filt_cnt   <= '0;
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
    end else begin
      filt_clk_d <= filt_clk;
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall   = filt_clk_d & ~filt_clk;
  assign sample = data_sync[1];

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state     <= FRM_IDLE;
      bit_cnt   <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      to_cnt    <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      // Timeout only runs mid-frame and restarts on every accepted clock edge.
      if (state == FRM_IDLE || fall) begin
        to_cnt <= '0;
      end else if (to_cnt == TW'(TIMEOUT - 1)) begin
        to_cnt    <= '0;
        state     <= FRM_IDLE;
        frame_err <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (fall) begin
        case (state)
          FRM_IDLE: begin
            if (!sample) begin
              state   <= FRM_DATA;
              bit_cnt <= '0;
            end
          end
          FRM_DATA: begin
            shift_q <= {sample, shift_q[7:1]};
            if (bit_cnt == 3'd7) begin
              state <= FRM_PARITY;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          FRM_PARITY: begin
            par_q <= sample;
            state <= FRM_STOP;
          end
          FRM_STOP: begin
            state <= FRM_IDLE;
            if (sample && (^{shift_q, par_q})) begin
              rx_byte  <= shift_q;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= FRM_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_arrow_decoder.sv
// PS/2 keyboard arrow-key decoder: receives bytes via ps2_rx_frame and tracks the
// make/break state of the four extended arrow keys.
module ps2_arrow_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 65000
) (
  input  logic                 pclk,
  input  logic                 rst,
  ps2_arrow_decoder_if.slave   bus
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic [1:0] frame_state;
  logic [1:0] dec_state;
  logic [3:0] key;
  logic [3:0] mask;

  ps2_rx_frame #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT)
  ) u_rx (
    .pclk      (pclk),
    .rst       (rst),
    .ps2_clk   (bus.ps2_clk),
    .ps2_data  (bus.ps2_data),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .state     (frame_state)
  );

  assign mask = arrow_mask(rx_byte);

  // Non-extended codes never touch key; a bad frame drops any pending prefix.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      dec_state <= DEC_BASE;
      key       <= 4'b0000;
    end else if (frame_err) begin
      dec_state <= DEC_BASE;
    end else if (rx_valid) begin
      case (dec_state)
        DEC_BASE: begin
          if (rx_byte == SC_EXT)      dec_state <= DEC_EXT;
          else if (rx_byte == SC_BRK) dec_state <= DEC_BRK;
          else                        dec_state <= DEC_BASE;
        end
        DEC_EXT: begin
          if (mask != 4'b0000) begin
            key       <= key | mask;
            dec_state <= DEC_BASE;
          end else if (rx_byte == SC_BRK) begin
            dec_state <= DEC_EXT_BRK;
          end else if (rx_byte == SC_EXT) begin
            dec_state <= DEC_EXT;
          end else begin
            dec_state <= DEC_BASE;
          end
        end
        DEC_EXT_BRK: begin
          key       <= key & ~mask;
          dec_state <= DEC_BASE;
        end
        DEC_BRK: dec_state <= DEC_BASE;
        default: dec_state <= DEC_BASE;
      endcase
    end
  end

  assign bus.key         = key;
  assign bus.rx_byte     = rx_byte;
  assign bus.rx_valid    = rx_valid;
  assign bus.frame_err   = frame_err;
  assign bus.frame_state = frame_state;
  assign bus.dec_state   = dec_state;

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Directed bench for ps2_arrow_decoder: PS/2 frames at 80 pclk per bit
// (12.5 kHz against a nominal 1 MHz pclk), received bytes checked from a queue.
module tb_ps2_arrow_decoder;
  import ps2_pkg::*;

  localparam int TB_TIMEOUT = 3000;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;
  int   rx_seen     = 0;
  int   err_seen    = 0;
  int   exp_rx      = 0;
  int   exp_err     = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  ps2_arrow_decoder_if bus ();

  ps2_arrow_decoder #(
    .FILTER_LEN (8),
    .TIMEOUT    (TB_TIMEOUT)
  ) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  // clock / reset
  always #5 pclk = ~pclk;

  // scoreboard monitor: every accepted byte must match the head of exp_q
  always @(negedge pclk) begin
    if (!rst) begin
      if (bus.rx_valid) begin
        rx_seen++;
        vectors++;
        mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        assert (bus.rx_byte === mon_exp) else begin
          miscompares++;
          $error("FAIL rx_byte: observed %0h expected %0h", bus.rx_byte, mon_exp);
        end
      end
      if (bus.frame_err) err_seen++;
    end
  end

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge pclk);
  endtask

  task automatic send_bits(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = fr[i];
      wait_cycles(20);
      bus.ps2_clk = 1'b0;
      wait_cycles(40);
      bus.ps2_clk = 1'b1;
      wait_cycles(20);
    end
    bus.ps2_data = 1'b1;
    wait_cycles(40);
  endtask

  task automatic send_good(input logic [7:0] b);
    exp_q.push_back(b);
    exp_rx++;
    send_bits(b, 1'b0, 11);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_key(input string tag, input logic [3:0] exp);
    wait_cycles(5);
    @(negedge pclk);
    check(tag, {28'd0, bus.key}, {28'd0, exp});
  endtask

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst = 1'b1;
    wait_cycles(5);
    @(negedge pclk);
    check("rst_key", {28'd0, bus.key}, 32'd0);
    check("rst_rx_byte", {24'd0, bus.rx_byte}, 32'd0);
    check("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check("rst_frame_state", {30'd0, bus.frame_state}, {30'd0, FRM_IDLE});
    check("rst_dec_state", {30'd0, bus.dec_state}, {30'd0, DEC_BASE});
    rst = 1'b0;
    wait_cycles(10);

    // make up
    send_good(SC_EXT);
    send_good(SC_UP);
    check_key("make_up", 4'b0001);
    check("two_rx_pulses", rx_seen, 32'd2);

    // break up, make left and right
    send_good(SC_EXT); send_good(SC_BRK); send_good(SC_UP);
    check_key("break_up", 4'b0000);
    send_good(SC_EXT); send_good(SC_LEFT);
    send_good(SC_EXT); send_good(SC_RIGHT);
    check_key("left_right", 4'b1100);
    send_good(SC_EXT); send_good(SC_BRK); send_good(SC_LEFT);
    send_good(SC_EXT); send_good(SC_BRK); send_good(SC_RIGHT);
    check_key("release_lr", 4'b0000);

    // parity error between prefix and code
    send_good(SC_EXT);
    send_bits(8'h00, 1'b1, 11);
    exp_err++;
    send_good(SC_UP);
    check_key("parity_err_key", 4'b0000);
    check("parity_err_cnt", err_seen, exp_err);

    // truncated frame then inactivity
    send_bits(8'hAA, 1'b0, 6);
    wait_cycles(TB_TIMEOUT + 100);
    exp_err++;
    @(negedge pclk);
    check("timeout_err_cnt", err_seen, exp_err);
    check("timeout_idle", {30'd0, bus.frame_state}, {30'd0, FRM_IDLE});
    send_good(SC_EXT); send_good(SC_DOWN);
    check_key("after_timeout", 4'b0010);
    send_good(SC_EXT); send_good(SC_BRK); send_good(SC_DOWN);
    check_key("release_down", 4'b0000);

    // short ps2_clk glitches on an idle line
    for (int g = 0; g < 5; g++) begin
      bus.ps2_clk = 1'b0;
      wait_cycles(3);
      bus.ps2_clk = 1'b1;
      wait_cycles(20);
    end
    @(negedge pclk);
    check("glitch_rx", rx_seen, exp_rx);
    check("glitch_err", err_seen, exp_err);
    check("glitch_state", {30'd0, bus.frame_state}, {30'd0, FRM_IDLE});

    // typematic, opposite arrows, non-extended break
    send_good(SC_EXT); send_good(SC_UP);
    send_good(SC_EXT); send_good(SC_UP);
    check_key("typematic", 4'b0001);
    send_good(SC_EXT); send_good(SC_DOWN);
    check_key("up_and_down", 4'b0011);
    send_good(SC_EXT); send_good(SC_BRK); send_good(SC_DOWN);
    send_good(SC_BRK); send_good(SC_UP);
    check_key("plain_break", 4'b0001);

    // reset in the middle of a frame
    send_bits(SC_UP, 1'b0, 4);
    @(negedge pclk);
    rst = 1'b1;
    #1;
    check("midrst_key", {28'd0, bus.key}, 32'd0);
    check("midrst_rx_byte", {24'd0, bus.rx_byte}, 32'd0);
    check("midrst_state", {30'd0, bus.frame_state}, {30'd0, FRM_IDLE});
    wait_cycles(5);
    rst = 1'b0;
    wait_cycles(10);
    send_good(SC_EXT); send_good(SC_DOWN);
    check_key("after_rst", 4'b0010);

    check("rx_total", rx_seen, exp_rx);
    check("err_total", err_seen, exp_err);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
